// File: rtl/matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader
//
// Upstream feeder for the matrix multiply stage. It takes a word stream over a
// valid/ready handshake: one dimension header, then the operand A elements,
// then the operand B elements, all row-major. It checks the header, packs the
// elements into two flat buffers and pulses readybit when both are complete.
//
// Ports
//   CLK            rising-edge clock
//   RST            synchronous, active-high reset
//   in_valid       in_data holds a valid word
//   in_data        header or element word
//   in_ready       loader accepts a word this cycle (registered, state-decoded)
//   flat_matrix_1  operand A, row-major, entries beyond R1*C1 are zero
//   flat_matrix_2  operand B, row-major, entries beyond R2*C2 are zero
//   R1, C1, R2, C2 dimensions latched from the last valid header
//   readybit       one-cycle pulse: buffers and dimensions are valid
//   err            one-cycle pulse: header rejected
//
// Header layout: [3:0]=R1, [7:4]=C1, [11:8]=R2, [15:12]=C2, upper bits ignored.
// -----------------------------------------------------------------------------
module matrix_stream_loader #(
  parameter int DATA_W    = 32,
  parameter int MAX_ELEMS = 8,
  parameter int DIM_W     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] flat_matrix_1 [0:MAX_ELEMS-1],
  output logic [DATA_W-1:0] flat_matrix_2 [0:MAX_ELEMS-1],
  output logic [DIM_W-1:0]  R1,
  output logic [DIM_W-1:0]  C1,
  output logic [DIM_W-1:0]  R2,
  output logic [DIM_W-1:0]  C2,
  output logic              readybit,
  output logic              err
);

  localparam int IDX_W  = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam int PROD_W = 2 * DIM_W;
  localparam logic [PROD_W-1:0] MAX_P = PROD_W'(MAX_ELEMS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD1,
    LOAD2,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_in_ready;
  logic                r_readybit;
  logic                r_err;
  logic [DIM_W-1:0]    r_r1, r_c1, r_r2, r_c2;
  logic [DATA_W-1:0]   r_buf1 [0:MAX_ELEMS-1];
  logic [DATA_W-1:0]   r_buf2 [0:MAX_ELEMS-1];

  logic                w_xfer;
  logic [DIM_W-1:0]    w_h_r1, w_h_c1, w_h_r2, w_h_c2;
  logic [PROD_W-1:0]   w_h_p1, w_h_p2;
  logic                w_hdr_ok;
  logic [PROD_W-1:0]   w_n1, w_n2;
  logic                w_last1, w_last2;

  assign w_xfer = in_valid && r_in_ready;

  // Header decode and validation. Products are full width (2*DIM_W), so a
  // 15x15 header cannot wrap around into the legal range.
  assign w_h_r1 = in_data[DIM_W-1:0];
  assign w_h_c1 = in_data[2*DIM_W-1:DIM_W];
  assign w_h_r2 = in_data[3*DIM_W-1:2*DIM_W];
  assign w_h_c2 = in_data[4*DIM_W-1:3*DIM_W];
  assign w_h_p1 = PROD_W'(w_h_r1) * PROD_W'(w_h_c1);
  assign w_h_p2 = PROD_W'(w_h_r2) * PROD_W'(w_h_c2);

  assign w_hdr_ok = (w_h_r1 != '0) && (w_h_c1 != '0) &&
                    (w_h_r2 != '0) && (w_h_c2 != '0) &&
                    (w_h_c1 == w_h_r2) &&
                    (w_h_p1 <= MAX_P) && (w_h_p2 <= MAX_P);

  // Element counts of the latched operands; a valid header guarantees both
  // are in 1..MAX_ELEMS, so the last index always fits in r_idx.
  assign w_n1    = PROD_W'(r_r1) * PROD_W'(r_c1);
  assign w_n2    = PROD_W'(r_r2) * PROD_W'(r_c2);
  assign w_last1 = (PROD_W'(r_idx) == (w_n1 - PROD_W'(1)));
  assign w_last2 = (PROD_W'(r_idx) == (w_n2 - PROD_W'(1)));

  // NOTE: the default assignment first means every path assigns
  // w_next_state, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_xfer && w_hdr_ok) w_next_state = LOAD1;
      LOAD1:   if (w_xfer && w_last1)  w_next_state = LOAD2;
      LOAD2:   if (w_xfer && w_last2)  w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_in_ready <= 1'b0;
      r_readybit <= 1'b0;
      r_err      <= 1'b0;
      r_r1       <= '0;
      r_c1       <= '0;
      r_r2       <= '0;
      r_c2       <= '0;
      // NOTE: the buffers are small register arrays visible on the ports,
      // so they are reset like any other register rather than left as RAM.
      for (int i = 0; i < MAX_ELEMS; i++) begin
        r_buf1[i] <= '0;
        r_buf2[i] <= '0;
      end
    end else begin
      r_state    <= w_next_state;
      // Handshake and status flags are decoded from the next state so they
      // line up with the state they describe and stay glitch-free.
      r_in_ready <= (w_next_state != DONE);
      r_readybit <= (w_next_state == DONE);
      r_err      <= (r_state == IDLE) && w_xfer && !w_hdr_ok;

      case (r_state)
        IDLE: begin
          if (w_xfer && w_hdr_ok) begin
            r_r1  <= w_h_r1;
            r_c1  <= w_h_c1;
            r_r2  <= w_h_r2;
            r_c2  <= w_h_c2;
            r_idx <= '0;
            for (int i = 0; i < MAX_ELEMS; i++) begin
              r_buf1[i] <= '0;
              r_buf2[i] <= '0;
            end
          end
        end
        LOAD1: begin
          if (w_xfer) begin
            r_buf1[r_idx] <= in_data;
            r_idx         <= w_last1 ? '0 : r_idx + IDX_W'(1);
          end
        end
        LOAD2: begin
          if (w_xfer) begin
            r_buf2[r_idx] <= in_data;
            r_idx         <= w_last2 ? '0 : r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign readybit      = r_readybit;
  assign err           = r_err;
  assign R1            = r_r1;
  assign C1            = r_c1;
  assign R2            = r_r2;
  assign C2            = r_c2;
  assign flat_matrix_1 = r_buf1;
  assign flat_matrix_2 = r_buf2;

endmodule
